// File: rtl/scarv_cop_issue.sv
// Issue stage between a CPU and an XCrypto-style coprocessor: forwards one
// custom-opcode instruction at a time and returns a result, abort, or timeout.
module scarv_cop_issue #(
  parameter logic [6:0] XC_OPCODE = 7'b0001011,
  parameter int         TIMEOUT   = 64
) (
  input  logic        g_clk,
  input  logic        g_reset,

  input  logic        cpu_insn_valid,
  output logic        cpu_insn_ready,
  input  logic [31:0] cpu_insn_enc,
  input  logic [31:0] cpu_rs1,

  output logic        cop_insn_req,
  input  logic        cop_insn_ack,
  output logic [31:0] cop_insn_enc,
  output logic [31:0] cop_rs1,

  input  logic        cop_rsp_valid,
  output logic        cop_rsp_ready,
  input  logic [4:0]  cop_rsp_rd,
  input  logic [31:0] cop_rsp_wdata,
  input  logic        cop_rsp_wen,
  input  logic        cop_rsp_abort,

  output logic        cpu_rsp_valid,
  input  logic        cpu_rsp_ready,
  output logic [4:0]  cpu_rsp_rd,
  output logic [31:0] cpu_rsp_wdata,
  output logic        cpu_rsp_wen,
  output logic        cpu_rsp_abort,
  output logic        cpu_rsp_timeout,

  output logic        busy,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_enc;
  logic [31:0] r_rs1;
  logic [7:0]  r_cnt;
  logic [4:0]  r_rsp_rd;
  logic [31:0] r_rsp_wdata;
  logic        r_rsp_wen;
  logic        r_rsp_abort;
  logic        r_rsp_timeout;

  logic        w_in_idle;
  logic        w_in_req;
  logic        w_in_wait;
  logic        w_in_rsp;
  logic        w_accept;
  logic        w_opc_hit;
  logic        w_cnt_last;

  // Every channel transfers on a cycle where valid (or req) and ready (or
  // ack) are both high at the rising edge; the issuer never drops a raised
  // valid/req and keeps its payload stable until that transfer happens.

  assign w_in_idle  = (r_state == ST_IDLE);
  assign w_in_req   = (r_state == ST_REQ);
  assign w_in_wait  = (r_state == ST_WAIT);
  assign w_in_rsp   = (r_state == ST_RSP);

  assign w_accept   = cpu_insn_valid && cpu_insn_ready;
  assign w_opc_hit  = (cpu_insn_enc[6:0] == XC_OPCODE);
  assign w_cnt_last = (r_cnt == LP_CNT_LAST);

  // Ready is gated by the reset input so nothing is accepted while held in reset.
  assign cpu_insn_ready  = w_in_idle && !g_reset;
  assign cop_insn_req    = w_in_req;
  assign cop_insn_enc    = r_enc;
  assign cop_rs1         = r_rs1;
  assign cop_rsp_ready   = w_in_wait;
  assign cpu_rsp_valid   = w_in_rsp;
  assign cpu_rsp_rd      = r_rsp_rd;
  assign cpu_rsp_wdata   = r_rsp_wdata;
  assign cpu_rsp_wen     = r_rsp_wen;
  assign cpu_rsp_abort   = r_rsp_abort;
  assign cpu_rsp_timeout = r_rsp_timeout;
  assign busy            = !w_in_idle;
  assign o_dbg_state     = r_state;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_opc_hit ? ST_REQ : ST_RSP;
        end
      end
      ST_REQ: begin
        if (cop_insn_ack) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cop_rsp_valid || w_cnt_last) begin
          w_state_nxt = ST_RSP;
        end
      end
      ST_RSP: begin
        if (cpu_rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A real response beats the timeout when both land in the same cycle.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_enc         <= 32'd0;
      r_rs1         <= 32'd0;
      r_cnt         <= 8'd0;
      r_rsp_rd      <= 5'd0;
      r_rsp_wdata   <= 32'd0;
      r_rsp_wen     <= 1'b0;
      r_rsp_abort   <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      if (w_in_idle && w_accept) begin
        r_enc <= cpu_insn_enc;
        r_rs1 <= cpu_rs1;
        if (!w_opc_hit) begin
          r_rsp_rd      <= cpu_insn_enc[11:7];
          r_rsp_wdata   <= 32'd0;
          r_rsp_wen     <= 1'b0;
          r_rsp_abort   <= 1'b1;
          r_rsp_timeout <= 1'b0;
        end
      end
      if (w_in_req && cop_insn_ack) begin
        r_cnt <= 8'd0;
      end
      if (w_in_wait) begin
        if (cop_rsp_valid) begin
          r_rsp_rd      <= cop_rsp_rd;
          r_rsp_wdata   <= cop_rsp_wdata;
          r_rsp_wen     <= cop_rsp_wen;
          r_rsp_abort   <= cop_rsp_abort;
          r_rsp_timeout <= 1'b0;
        end else if (w_cnt_last) begin
          r_rsp_rd      <= r_enc[11:7];
          r_rsp_wdata   <= 32'd0;
          r_rsp_wen     <= 1'b0;
          r_rsp_abort   <= 1'b1;
          r_rsp_timeout <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

  logic w_unused;
  assign w_unused = w_in_rsp;

endmodule

// File: doc/scarv_cop_issue.md
SCARV_COP_ISSUE -- requirements
Module: scarv_cop_issue

Interface
REQ-001 SHALL have parameter XC_OPCODE, default 7'b0001011, major opcode identifying coprocessor instructions.
REQ-002 SHALL have parameter TIMEOUT, default 64, response-wait limit in cycles (legal range 2..255).
REQ-003 SHALL have port g_clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port g_reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port cpu_insn_valid  in  1  CPU presents an instruction.
REQ-006 SHALL have port cpu_insn_ready  out  1  issuer accepts an instruction.
REQ-007 SHALL have port cpu_insn_enc  in  32  encoded instruction.
REQ-008 SHALL have port cpu_rs1  in  32  GPR rs1 value.
REQ-009 SHALL have port cop_insn_req  out  1  request to coprocessor.
REQ-010 SHALL have port cop_insn_ack  in  1  coprocessor accepted request.
REQ-011 SHALL have ports cop_insn_enc  out  32 and cop_rs1  out  32  latched instruction and operand.
REQ-012 SHALL have port cop_rsp_valid  in  1  coprocessor result available.
REQ-013 SHALL have port cop_rsp_ready  out  1  issuer takes result.
REQ-014 SHALL have ports cop_rsp_rd  in  5, cop_rsp_wdata  in  32, cop_rsp_wen  in  1, cop_rsp_abort  in  1  result fields.
REQ-015 SHALL have port cpu_rsp_valid  out  1  result to CPU.
REQ-016 SHALL have port cpu_rsp_ready  in  1  CPU takes result.
REQ-017 SHALL have ports cpu_rsp_rd  out  5, cpu_rsp_wdata  out  32, cpu_rsp_wen  out  1, cpu_rsp_abort  out  1, cpu_rsp_timeout  out  1  registered result fields.
REQ-018 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, REQ, WAIT, RSP; one instruction outstanding at most.
REQ-020 cpu_insn_ready SHALL be 1 only in IDLE; acceptance = cpu_insn_valid && cpu_insn_ready.
REQ-021 On acceptance SHALL latch cpu_insn_enc and cpu_rs1; next state REQ if enc[6:0]==XC_OPCODE, else RSP.
REQ-022 Opcode mismatch SHALL load rd=enc[11:7], wdata=0, wen=0, abort=1, timeout=0; no coprocessor request issued.
REQ-023 In REQ, cop_insn_req SHALL be 1 with cop_insn_enc/cop_rs1 held stable; on cop_insn_ack move to WAIT, clear counter.
REQ-024 cop_insn_req SHALL be 0 outside REQ; ack outside REQ ignored.
REQ-025 In WAIT, cop_rsp_ready SHALL be 1; elsewhere 0; cop_rsp_valid outside WAIT ignored (coprocessor holds it).
REQ-026 In WAIT with cop_rsp_valid: latch rd, wdata, wen, abort from cop_rsp_*, timeout=0, go RSP.
REQ-027 In WAIT without cop_rsp_valid: 8-bit counter increments; when counter==TIMEOUT-1 load rd=enc[11:7], wdata=0, wen=0, abort=1, timeout=1, go RSP.
REQ-028 cop_rsp_valid in the same cycle the counter hits TIMEOUT-1 SHALL take precedence (normal response, timeout=0).
REQ-029 In RSP, cpu_rsp_valid SHALL be 1 with fields stable; on cpu_rsp_ready go IDLE.
REQ-030 Minimum latency: acceptance -> cpu_rsp_valid = 3 cycles with same-cycle ack and response on first WAIT cycle; mismatch path = 1 cycle.
REQ-031 New instruction SHALL NOT be accepted in the cycle RSP completes (ready asserted from next IDLE cycle).

Reset
REQ-032 On g_reset SHALL asynchronously enter IDLE; counter, latched instruction/operand, and all cpu_rsp_* fields 0.
REQ-033 During/after reset, cpu_insn_ready=0 while g_reset high, then 1; cop_insn_req, cop_rsp_ready, cpu_rsp_valid, busy = 0.
REQ-034 Reset mid-transaction SHALL discard the outstanding instruction without emitting any response.

Verification
REQ-035 Valid enc=0x0000058B (opcode 0x0B), rs1=0x12345678, ack in REQ, rsp rd=5 wdata=0xCAFEF00D wen=1 one cycle later -> cop_insn_enc=0x0000058B, cpu_rsp rd=5 wdata=0xCAFEF00D wen=1 abort=0.
REQ-036 enc=0x00000533 (opcode 0x33) -> no cop_insn_req, next cycle cpu_rsp_valid, rd=10, abort=1, wen=0.
REQ-037 Ack given, no response for TIMEOUT=64 cycles -> cpu_rsp abort=1 timeout=1 after 64 WAIT cycles; late cop_rsp_valid ignored.
REQ-038 Ack delayed 10 cycles, cpu_rsp_ready low 5 cycles -> req and rsp fields stable throughout, busy=1, cpu_insn_ready=0.
REQ-039 g_reset asserted in WAIT -> immediate IDLE, all outputs 0, no cpu_rsp_valid afterwards; next instruction completes normally.
REQ-040 cop_rsp_valid coincident with counter==TIMEOUT-1 -> normal response, timeout=0.
